// File: rtl/spi_fifo_master.sv
// SPI mode-0 master that pops 32-bit words from a TX FIFO, shifts them out MSB first,
// and pushes the word assembled from miso into an RX FIFO.
module spi_fifo_master #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_data_valid,
    input  logic              rx_full,
    output logic              rx_wr_en,
    output logic [WORD_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t            r_state;
    logic [7:0]        r_div;
    logic [4:0]        r_bit;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rx;
    logic [WORD_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_fifo_rd_en;
    logic              r_rx_wr_en;
    logic              r_busy;

    state_t            w_state;
    logic [7:0]        w_div;
    logic [4:0]        w_bit;
    logic [WORD_W-1:0] w_tx;
    logic [WORD_W-1:0] w_rx;
    logic [WORD_W-1:0] w_rx_data;
    logic              w_sclk;
    logic              w_mosi;

    // Next-state and datapath decode; all outputs are registered from these values.
    always_comb begin
        w_state   = r_state;
        w_div     = r_div;
        w_bit     = r_bit;
        w_tx      = r_tx;
        w_rx      = r_rx;
        w_rx_data = r_rx_data;
        w_sclk    = r_sclk;
        w_mosi    = r_mosi;
        case (r_state)
            IDLE: begin
                if (!fifo_empty && !rx_full) begin
                    w_state = FETCH;
                end else begin
                    w_state = IDLE;
                end
            end
            FETCH: begin
                w_state = WAIT;
            end
            WAIT: begin
                if (fifo_data_valid) begin
                    w_state = SHIFT;
                    w_tx    = fifo_data;
                    w_mosi  = fifo_data[WORD_W-1];
                    w_rx    = {WORD_W{1'b0}};
                    w_div   = 8'd0;
                    w_bit   = 5'd0;
                    w_sclk  = 1'b0;
                end else begin
                    w_state = IDLE;
                end
            end
            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div  = 8'd0;
                    w_sclk = ~r_sclk;
                    if (!r_sclk) begin
                        // Rising edge: sample miso into the LSB end.
                        w_rx = {r_rx[WORD_W-2:0], miso};
                    end else begin
                        w_tx   = {r_tx[WORD_W-2:0], 1'b0};
                        w_mosi = r_tx[WORD_W-2];
                        if (r_bit == 5'd31) begin
                            w_state   = DONE;
                            w_mosi    = 1'b0;
                            w_rx_data = r_rx;
                        end else begin
                            w_bit = r_bit + 5'd1;
                        end
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_div        <= 8'd0;
            r_bit        <= 5'd0;
            r_tx         <= {WORD_W{1'b0}};
            r_rx         <= {WORD_W{1'b0}};
            r_rx_data    <= {WORD_W{1'b0}};
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_fifo_rd_en <= 1'b0;
            r_rx_wr_en   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_div        <= w_div;
            r_bit        <= w_bit;
            r_tx         <= w_tx;
            r_rx         <= w_rx;
            r_rx_data    <= w_rx_data;
            r_sclk       <= w_sclk;
            r_mosi       <= w_mosi;
            r_cs_n       <= (w_state != SHIFT);
            r_fifo_rd_en <= (w_state == FETCH);
            r_rx_wr_en   <= (w_state == DONE);
            r_busy       <= (w_state != IDLE);
        end
    end

    assign fifo_rd_en = r_fifo_rd_en;
    assign rx_wr_en   = r_rx_wr_en;
    assign rx_data    = r_rx_data;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign cs_n       = r_cs_n;
    assign busy       = r_busy;

endmodule

// File: doc/spi_fifo_master.md
SPI_FIFO_MASTER -- requirements
Module: spi_fifo_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, sclk half-period in clk cycles (legal range 1..255).
REQ-002 SHALL provide parameter WORD_W, default 32, bits per SPI word (fixed at 32 for this release).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  TX FIFO empty flag.
REQ-006 fifo_rd_en  output  1  TX FIFO read strobe, one-cycle pulse.
REQ-007 fifo_data  input  32  TX FIFO read data.
REQ-008 fifo_data_valid  input  1  TX FIFO read data valid, one cycle after fifo_rd_en.
REQ-009 rx_full  input  1  RX FIFO full flag.
REQ-010 rx_wr_en  output  1  RX FIFO write strobe, one-cycle pulse.
REQ-011 rx_data  output  32  received word, valid while rx_wr_en=1.
REQ-012 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 mosi  output  1  SPI serial out, MSB first.
REQ-014 miso  input  1  SPI serial in, MSB first.
REQ-015 cs_n  output  1  SPI chip select, active-low.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 State machine SHALL have states IDLE, FETCH, WAIT, SHIFT, DONE.
REQ-018 IDLE -> FETCH when fifo_empty=0 and rx_full=0; otherwise remain in IDLE.
REQ-019 FETCH lasts exactly 1 cycle with fifo_rd_en=1; fifo_rd_en SHALL be 0 in all other states.
REQ-020 WAIT lasts 1 cycle: if fifo_data_valid=1, capture fifo_data into TX shift register, drive mosi=fifo_data[31], go to SHIFT; else return to IDLE with cs_n kept high.
REQ-021 cs_n SHALL be 0 exactly while in SHIFT: 64*CLK_DIV consecutive cycles per word.
REQ-022 In SHIFT an 8-bit divider counts 0..CLK_DIV-1; at terminal count sclk toggles and divider clears.
REQ-023 On a low->high sclk toggle, miso SHALL be shifted into the RX shift register LSB end (MSB-first assembly).
REQ-024 On a high->low sclk toggle, the TX shift register shifts left and mosi presents the next bit.
REQ-025 After the 32nd high->low toggle, SHIFT -> DONE; exactly 32 rising sclk edges per word.
REQ-026 DONE lasts 1 cycle: rx_wr_en=1, rx_data=assembled word, cs_n=1, then -> IDLE.
REQ-027 Back-to-back words: cs_n high at least 3 cycles (DONE, IDLE, FETCH, WAIT → 4 with normal FIFO timing).
REQ-028 sclk=0 and mosi=0 whenever cs_n=1.
REQ-029 Transaction latency from leaving IDLE to rx_wr_en: 2 + 64*CLK_DIV cycles.
REQ-030 rx_full changing during a transaction SHALL NOT abort it; it gates only the IDLE -> FETCH decision.
REQ-031 rx_data SHALL hold last received word between writes.

Reset
REQ-032 While rst=1: state=IDLE, cs_n=1, sclk=0, mosi=0, fifo_rd_en=0, rx_wr_en=0, busy=0, rx_data=0, shift registers and counters 0.
REQ-033 rst mid-transaction SHALL discard the in-flight word (no rx_wr_en, popped TX word lost); after release, behave as from power-up.

Verification
REQ-034 Assert rst -> cs_n=1, sclk=0, mosi=0, fifo_rd_en=0, rx_wr_en=0, busy=0 immediately, without clk edge.
REQ-035 CLK_DIV=2, mosi looped to miso, FIFO word 0xA5A50F0F -> one fifo_rd_en pulse, cs_n low 128 cycles, 32 sclk rising edges, rx_wr_en one pulse with rx_data=0xA5A50F0F, 130 cycles after FETCH entry.
REQ-036 fifo_empty=1 held 1000 cycles -> fifo_rd_en never asserted, busy=0, cs_n=1.
REQ-037 fifo_empty=0, rx_full=1 for 50 cycles then 0 -> no fifo_rd_en while rx_full=1; FETCH within 1 cycle after drop.
REQ-038 Two words 0x00000001, 0x80000000 queued, miso driven by model returning 0xDEADBEEF then 0x12345678 -> rx_data written in that order, cs_n high ≥3 cycles between words.
REQ-039 rst pulsed after 10th sclk rising edge -> no rx_wr_en; next queued word transmitted complete and correct after release.
